// File: rtl/sfifo_22_16_arb.sv
// Round-robin write arbiter and read sequencer for one shared show-head FIFO.
// Four requesters share the write port; one consumer pops; a flush drains the FIFO.
module sfifo_22_16_arb #(
  parameter int DATA_WIDTH = 22,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*DATA_WIDTH-1:0] iv_in_data,
  input  logic [3:0]              iv_in_valid,
  output logic [3:0]              ov_in_ready,
  output logic [DATA_WIDTH-1:0]   ov_fifo_data,
  output logic                    o_fifo_wrreq,
  output logic                    o_fifo_rdreq,
  input  logic [DATA_WIDTH-1:0]   iv_fifo_q,
  input  logic                    i_fifo_rdempty,
  input  logic                    i_fifo_wrfull,
  output logic [DATA_WIDTH-1:0]   ov_out_data,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  input  logic                    i_flush,
  output logic                    o_flush_done,
  output logic [CNT_WIDTH-1:0]    ov_occupancy,
  output logic                    o_ovf_err
);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t                  state;
  logic [1:0]              ptr;
  logic [3:0]              grant;
  logic [1:0]              grant_idx;
  logic                    found;
  logic                    grant_en;
  logic                    xfer;
  logic [CNT_WIDTH:0]      occ_sum;
  logic [DATA_WIDTH-1:0]   data_sel;
  logic                    wrreq_p1;
  logic [DATA_WIDTH-1:0]   data_p1;
  logic [CNT_WIDTH-1:0]    occupancy;
  logic                    flush_done;
  logic                    ovf_err;

  // The in-flight write already owns a slot, so it counts toward the limit.
  assign occ_sum  = {1'b0, occupancy} + {{CNT_WIDTH{1'b0}}, wrreq_p1};
  assign grant_en = (state == RUN) && !i_flush &&
                    (occ_sum < (CNT_WIDTH+1)'(DEPTH));

  always_comb begin
    logic [1:0] idx;
    grant     = '0;
    grant_idx = ptr;
    found     = 1'b0;
    idx       = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && iv_in_valid[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    if (grant_en && found) grant[grant_idx] = 1'b1;
  end

  assign xfer        = grant_en && found;
  assign data_sel    = iv_in_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign ov_in_ready = grant;

  // Stage p0 -> p1: accepted descriptor becomes the FIFO write one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wrreq_p1 <= 1'b0;
      data_p1  <= '0;
      ptr      <= 2'd0;
    end else begin
      wrreq_p1 <= xfer;
      if (xfer) begin
        data_p1 <= data_sel;
        ptr     <= grant_idx + 2'd1;
      end
    end
  end

  assign o_fifo_wrreq = wrreq_p1;
  assign ov_fifo_data = data_p1;

  assign o_out_valid  = !i_fifo_rdempty && (state == RUN);
  assign o_fifo_rdreq = (state == FLUSH) ? !i_fifo_rdempty
                                         : (o_out_valid && i_out_ready);
  assign ov_out_data  = iv_fifo_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      occupancy <= '0;
    end else begin
      case ({wrreq_p1, o_fifo_rdreq})
        2'b10:   if (occupancy < CNT_WIDTH'(DEPTH)) occupancy <= occupancy + CNT_WIDTH'(1);
        2'b01:   if (occupancy != '0) occupancy <= occupancy - CNT_WIDTH'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign ov_occupancy = occupancy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        RUN:   if (i_flush) state <= FLUSH;
        FLUSH: begin
          // A write accepted just before the flush must land before we finish.
          if (occupancy == '0 && !wrreq_p1) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end
        end
        DONE:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign o_flush_done = flush_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ovf_err <= 1'b0;
    else if (i_fifo_wrfull && wrreq_p1) ovf_err <= 1'b1;
  end

  assign o_ovf_err = ovf_err;

endmodule
